// File: rtl/mem_pkg.sv
// Shared encodings for the memory controller: access sizes, FSM states, port ids
// and the alignment rule used by the arbiter.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int RAM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    // Size 3 is reserved and always rejected as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the CPU and the 32-bit RAM: store replication with
// write strobes, and load extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_w_data_o,
    output logic [3:0]  st_w_sel_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_r_data_i,
    output logic [31:0] ld_rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        st_w_data_o = st_wdata_i;
        st_w_sel_o  = 4'b1111;
        case (st_size_i)
            SIZE_B: begin
                st_w_data_o = {4{st_wdata_i[7:0]}};
                st_w_sel_o  = 4'b0001 << st_off_i;
            end
            SIZE_H: begin
                st_w_data_o = {2{st_wdata_i[15:0]}};
                st_w_sel_o  = 4'b0011 << {st_off_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign ld_byte = ld_r_data_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = ld_r_data_i[{ld_off_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_rdata_o = ld_r_data_i;
        case (ld_size_i)
            SIZE_B:  ld_rdata_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_rdata_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the instruction-fetch and data ports onto one single-port RAM with
// a one-cycle read latency; loads respond two cycles after acceptance.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_AW     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [1:0]            dm_size,
    input  logic                  dm_unsigned,
    input  logic [31:0]           dm_wdata,
    output logic                  dm_ready,
    output logic                  dm_rvalid,
    output logic [31:0]           dm_rdata,
    output logic                  dm_err,
    output logic                  ram_re,
    output logic [RAM_AW-1:0]     ram_r_addr,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_w_addr,
    output logic [31:0]           ram_w_data,
    output logic [3:0]            ram_w_sel,
    input  logic [31:0]           ram_r_data
);

    state_e      state_q;
    port_e       last_grant_q;
    port_e       rd_port_q;
    logic [1:0]  rd_size_q;
    logic [1:0]  rd_off_q;
    logic        rd_uns_q;
    logic        if_rvalid_q, dm_rvalid_q, dm_err_q;
    logic [31:0] if_rdata_q, dm_rdata_q;

    logic        grant_dm, grant_if, dm_misal;
    logic [31:0] st_w_data, ld_data;
    logic [3:0]  st_w_sel;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[ADDR_WIDTH-1:RAM_AW+2], if_addr[1:0],
                                dm_addr[ADDR_WIDTH-1:RAM_AW+2]};

    assign dm_misal = is_misaligned(dm_size, dm_addr[1:0]);

    // DM has priority except right after its own grant while IF is waiting.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_dm = dm_req && !(last_grant_q == PORT_DM && if_req);
            grant_if = if_req && !grant_dm;
        end
    end

    assign if_ready = grant_if;
    assign dm_ready = grant_dm;

    always_comb begin
        ram_re     = grant_if || (grant_dm && !dm_we && !dm_misal);
        ram_we     = grant_dm && dm_we && !dm_misal;
        ram_r_addr = '0;
        ram_w_addr = '0;
        ram_w_data = '0;
        ram_w_sel  = '0;
        if (ram_re) begin
            ram_r_addr = grant_dm ? dm_addr[RAM_AW+1:2] : if_addr[RAM_AW+1:2];
        end
        if (ram_we) begin
            ram_w_addr = dm_addr[RAM_AW+1:2];
            ram_w_data = st_w_data;
            ram_w_sel  = st_w_sel;
        end
    end

    mem_lane_align u_align (
        .st_size_i     (dm_size),
        .st_off_i      (dm_addr[1:0]),
        .st_wdata_i    (dm_wdata),
        .st_w_data_o   (st_w_data),
        .st_w_sel_o    (st_w_sel),
        .ld_size_i     (rd_size_q),
        .ld_off_i      (rd_off_q),
        .ld_unsigned_i (rd_uns_q),
        .ld_r_data_i   (ram_r_data),
        .ld_rdata_o    (ld_data)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_IF;
            rd_port_q    <= PORT_IF;
            rd_size_q    <= SIZE_W;
            rd_off_q     <= 2'b00;
            rd_uns_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            dm_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_err_q    <= grant_dm && dm_misal;
            case (state_q)
                ST_IDLE: begin
                    if (grant_dm) begin
                        last_grant_q <= PORT_DM;
                    end else if (grant_if) begin
                        last_grant_q <= PORT_IF;
                    end
                    if (ram_re) begin
                        state_q   <= ST_RD_WAIT;
                        rd_port_q <= grant_dm ? PORT_DM : PORT_IF;
                        rd_size_q <= grant_dm ? dm_size : SIZE_W;
                        rd_off_q  <= grant_dm ? dm_addr[1:0] : 2'b00;
                        rd_uns_q  <= grant_dm & dm_unsigned;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_port_q == PORT_DM) begin
                        dm_rdata_q  <= ld_data;
                        dm_rvalid_q <= 1'b1;
                    end else begin
                        if_rdata_q  <= ld_data;
                        if_rvalid_q <= 1'b1;
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;

endmodule
